// File: rtl/sr_latch_driver.sv
// Sequencer for an external SR latch: drives set/reset with a setup cycle, an
// enable pulse, a readback check with timeout, and a dead time. Every output
// comes straight from a flop.
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 2,  // 1..15 cycles of lat_en per command
  parameter int unsigned DEAD_W  = 1,  // 1..15 idle cycles after each command
  parameter int unsigned TIMEOUT = 8   // 1..255 readback cycles before giving up
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic lat_s,
  output logic lat_r,
  output logic lat_en,
  input  logic lat_q,
  input  logic lat_qb,
  output logic done,
  output logic err,
  output logic state_q
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StCheck,
    StDead
  } fsm_e;

  // One shared counter, wide enough for the longest state (TIMEOUT up to 255).
  localparam logic [7:0] PulseLast = 8'(PULSE_W - 1);
  localparam logic [7:0] CheckLast = 8'(TIMEOUT - 1);
  localparam logic [7:0] DeadLast  = 8'(DEAD_W - 1);

  fsm_e       fsm_q, fsm_d;
  logic [7:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic       vrf_q, vrf_d;
  logic       ready_q, ready_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       en_q, en_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       drive;
  logic       pass;

  // Readback matches the commanded value on both rails.
  assign pass = (lat_q == op_q) && (lat_qb == ~op_q);

  // Next-state, counter and registered-output decode.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    vrf_d  = vrf_q;
    done_d = 1'b0;
    err_d  = 1'b0;

    unique case (fsm_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          op_d  = req_op;
          fsm_d = StSetup;
        end
      end
      StSetup: begin
        fsm_d = StPulse;
        cnt_d = '0;
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          fsm_d = StCheck;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCheck: begin
        if (pass) begin
          fsm_d  = StDead;
          cnt_d  = '0;
          done_d = 1'b1;
          vrf_d  = op_q;
        end else if (cnt_q == CheckLast) begin
          fsm_d = StDead;
          cnt_d = '0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDead: begin
        if (cnt_q == DeadLast) begin
          fsm_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        fsm_d = StIdle;
        cnt_d = '0;
      end
    endcase

    // Outputs follow the state being entered so they can be flopped.
    drive   = (fsm_d == StSetup) || (fsm_d == StPulse) || (fsm_d == StCheck);
    s_d     = drive & op_d;
    r_d     = drive & ~op_d;
    en_d    = (fsm_d == StPulse);
    ready_d = (fsm_d == StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      vrf_q   <= 1'b0;
      ready_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      vrf_q   <= vrf_d;
      ready_q <= ready_d;
      s_q     <= s_d;
      r_q     <= r_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign lat_s     = s_q;
  assign lat_r     = r_q;
  assign lat_en    = en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign state_q   = vrf_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a command-level timeline model predicts every
// output each cycle from the acceptance offset; the latch readback is driven
// from the same timeline (good from a chosen CHECK cycle on, or never).
module tb_sr_latch_driver;

  localparam int PW = 2;
  localparam int DW = 1;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset, req_valid, req_op, lat_q, lat_qb;
  logic req_ready, lat_s, lat_r, lat_en, done, err, state_q;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .PULSE_W(PW),
    .DEAD_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_ready(req_ready),
    .lat_s    (lat_s),
    .lat_r    (lat_r),
    .lat_en   (lat_en),
    .lat_q    (lat_q),
    .lat_qb   (lat_qb),
    .done     (done),
    .err      (err),
    .state_q  (state_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model: offset counts edges since the acceptance edge.
  bit m_busy     = 1'b0;
  int m_off      = 0;
  bit m_op       = 1'b0;
  int m_k        = 0;   // CHECK cycle that passes; 0 means never passes
  int m_bad      = 0;   // readback pattern used while not passing
  bit m_state    = 1'b0;
  bit m_rst_last = 1'b1;
  bit e_ready    = 1'b0;
  int cmd_count  = 0;

  // Stimulus controls.
  bit p_op       = 1'b0;
  int p_k        = 1;
  int p_bad      = 0;
  bit want_cmd   = 1'b0;
  bit hold_valid = 1'b0;
  bit force_rst  = 1'b1;
  int rst_at     = 0;
  bit rnd_rb     = 1'b0;
  bit noise      = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cmd %0d off %0d)", tag, obs, want, cmd_count,
             m_off);
    end
  endtask

  task automatic cycle();
    bit acc, was_rst, setup, pulse, check, fdead, act;
    int kk, c;
    acc     = !reset && req_valid && e_ready;
    was_rst = reset;
    @(posedge clk);
    #1;
    if (was_rst) begin
      m_busy = 1'b0; m_state = 1'b0; m_rst_last = 1'b1; rst_at = 0;
    end else begin
      m_rst_last = 1'b0;
      if (acc) begin
        m_busy = 1'b1; m_off = 1; m_op = p_op; m_k = p_k; m_bad = p_bad;
        cmd_count++; want_cmd = 1'b0;
      end else if (m_busy) begin
        m_off++;
        kk = (m_k == 0) ? TO : m_k;
        if (m_off == 2 + PW + kk && m_k != 0) m_state = m_op;
        if (m_off == 2 + PW + kk + DW) m_busy = 1'b0;
      end
    end

    kk    = (m_k == 0) ? TO : m_k;
    setup = m_busy && m_off == 1;
    pulse = m_busy && m_off >= 2 && m_off <= 1 + PW;
    check = m_busy && m_off >= 2 + PW && m_off <= 1 + PW + kk;
    fdead = m_busy && m_off == 2 + PW + kk;
    act   = setup | pulse | check;
    e_ready = !m_busy && !m_rst_last;

    chk("req_ready", req_ready, e_ready);
    chk("lat_s", lat_s, act & m_op);
    chk("lat_r", lat_r, act & ~m_op);
    chk("lat_en", lat_en, pulse);
    chk("done", done, fdead && m_k != 0);
    chk("err", err, fdead && m_k == 0);
    chk("state_q", state_q, m_state);
    chk("inv_s_and_r", lat_s & lat_r, 1'b0);
    chk("inv_en_onehot", lat_en ? (lat_s ^ lat_r) : 1'b1, 1'b1);

    // Readback seen by the DUT for the cycle just observed.
    if (check) begin
      c = m_off - (1 + PW);
      if (m_k != 0 && c >= m_k) begin
        lat_q = m_op; lat_qb = ~m_op;
      end else begin
        case (m_bad)
          0:       begin lat_q = ~m_op; lat_qb = m_op;  end
          1:       begin lat_q = 1'b1;  lat_qb = 1'b1;  end
          2:       begin lat_q = 1'b0;  lat_qb = 1'b0;  end
          3:       begin lat_q = m_op;  lat_qb = m_op;  end
          default: begin lat_q = ~m_op; lat_qb = ~m_op; end
        endcase
      end
    end else if (rnd_rb) begin
      {lat_q, lat_qb} = 2'($urandom_range(0, 3));
    end else begin
      lat_q = m_state; lat_qb = ~m_state;
    end

    reset = force_rst || (rst_at != 0 && m_busy && m_off == rst_at);
    if (hold_valid || (want_cmd && e_ready)) req_valid = 1'b1;
    else req_valid = noise && !e_ready && ($urandom_range(0, 1) == 1);
    req_op = e_ready ? p_op : 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input bit op, input int k, input int bad, input int rat);
    int start, n;
    p_op = op; p_k = k; p_bad = bad; rst_at = rat;
    start = cmd_count; want_cmd = 1'b1; n = 0;
    while (cmd_count == start && n < 50) begin cycle(); n++; end
    chk("accept_wait", cmd_count != start, 1'b1);
    want_cmd = 1'b0;
    n = 0;
    while (m_busy && n < 400) begin cycle(); n++; end
    chk("complete_wait", m_busy, 1'b0);
    rst_at = 0;
  endtask

  initial begin
    int start, n;
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; lat_q = 1'b0; lat_qb = 1'b1;

    // Reset held for two edges, then ready must appear one cycle later.
    cycle();
    force_rst = 1'b0;
    cycle();
    cycle();

    // Set with ideal readback, then clear, both passing in the first CHECK cycle.
    issue(1'b1, 1, 0, 0);
    issue(1'b0, 1, 0, 0);
    // Late pass and refresh of the same value.
    issue(1'b0, 3, 2, 0);
    // Stuck latch q=0/qb=1 on set: full timeout, err, state unchanged.
    issue(1'b1, 0, 0, 0);
    // qb stuck at q (both 1) on set: never passes.
    issue(1'b1, 0, 1, 0);
    // q correct but qb wrong until the last allowed CHECK cycle.
    issue(1'b1, TO, 3, 0);
    // Reset in the second PULSE cycle aborts, then a fresh command completes.
    issue(1'b1, 1, 0, 3);
    issue(1'b1, 1, 0, 0);

    // req_valid held high across three back-to-back commands.
    hold_valid = 1'b1; p_k = 2; p_bad = 4; p_op = 1'b0;
    start = cmd_count; n = 0;
    while (cmd_count < start + 3 && n < 200) begin
      cycle();
      p_op = ~m_op;
      n++;
    end
    hold_valid = 1'b0;
    chk("hold_three", cmd_count == start + 3, 1'b1);
    n = 0;
    while (m_busy && n < 100) begin cycle(); n++; end

    // Randomised commands with noisy inputs and occasional mid-command reset.
    rnd_rb = 1'b1; noise = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, TO)), int'($urandom_range(0, 4)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 14)) : 0);
      if ($urandom_range(0, 3) == 0) cycle();
    end
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
